gray_counter_gen: RTL and testbench

//  Generates a WIDTH-bit Gray-code sequence that feeds the Gray-to-binary decoder stage.
//  An internal binary counter advances once per prescaler tick, up or down.
//  The Gray output is registered and updates one code step at a time, so it is

---
 rtl/gray_counter_gen.sv | 94 +++++++++
 tb/tb_gray_counter_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_gen.sv
// Prescaled up/down binary counter whose Gray code is registered for glitch-free output.
// Supports synchronous load, wrap or saturate at the ends, and a one-cycle update strobe.
module gray_counter_gen #(
  parameter int WIDTH = 3,
  parameter int DIV   = 50_000_000,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid,
  output logic             tc
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_bin, w_bin_nxt, r_gray;
  logic             r_valid, w_valid_nxt;
  logic             w_at_lim;

  assign w_at_lim = up ? (r_bin == BIN_MAX) : (r_bin == '0);
  assign tc       = w_at_lim;
  assign gray_out = r_gray;
  assign valid    = r_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_valid_nxt = 1'b0;
    if (load) begin
      w_bin_nxt   = load_bin;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b1;
      w_state_nxt = en ? RUN : IDLE;
    end else begin
      case (r_state)
        // IDLE with en high counts on the same edge it enters RUN
        IDLE, RUN: begin
          if (!en) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RUN;
            if (r_cnt == CNT_MAX) begin
              w_cnt_nxt = '0;
              if (w_at_lim && (WRAP == 0)) begin
                w_state_nxt = SAT;
              end else begin
                w_bin_nxt   = up ? r_bin + 1'b1 : r_bin - 1'b1;
                w_valid_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        SAT: begin
          if (!en) begin
            w_state_nxt = IDLE;
          end else if (!w_at_lim) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_gray  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_gray  <= w_bin_nxt ^ (w_bin_nxt >> 1);
      r_valid <= w_valid_nxt;
    end
  end
endmodule

// File: tb/tb_gray_counter_gen.sv
// Directed checks on three instances (wrap/DIV=4, saturate/DIV=4, wrap/DIV=1)
// plus a randomized run of the wrapping instance against a small reference model.
module tb_gray_counter_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, up_a, ld_a, v_a, tc_a;
  logic en_b, up_b, ld_b, v_b, tc_b;
  logic en_c, up_c, ld_c, v_c, tc_c;
  logic [2:0] lb_a, g_a, lb_b, g_b, lb_c, g_c;

  gray_counter_gen #(.WIDTH(3), .DIV(4), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(ld_a), .load_bin(lb_a),
    .gray_out(g_a), .valid(v_a), .tc(tc_a));
  gray_counter_gen #(.WIDTH(3), .DIV(4), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(ld_b), .load_bin(lb_b),
    .gray_out(g_b), .valid(v_b), .tc(tc_b));
  gray_counter_gen #(.WIDTH(3), .DIV(1), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(ld_c), .load_bin(lb_c),
    .gray_out(g_c), .valid(v_c), .tc(tc_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [2:0] seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] m_bin, prev_g;
  int         m_cnt;
  logic       m_vld;

  initial begin
    rst = 1'b1;
    en_a = 0; up_a = 1; ld_a = 0; lb_a = 0;
    en_b = 0; up_b = 0; ld_b = 0; lb_b = 0;
    en_c = 0; up_c = 1; ld_c = 0; lb_c = 0;
    step(2);
    chk("rst_gray", g_a, 0);
    chk("rst_valid", v_a, 0);
    chk("rst_tc_up", tc_a, 0);
    chk("rst_tc_down", tc_b, 1);
    chk("rst_gray_c", g_c, 0);

    // Full up sequence with wrap, one step per 4 clocks
    rst = 0; en_a = 1;
    for (int k = 0; k < 8; k++) begin
      step(3);
      chk("seq_hold_valid", v_a, 0);
      step(1);
      chk("seq_gray", g_a, seq[k]);
      chk("seq_valid", v_a, 1);
    end

    // Pause with cnt=2; resume needs exactly 2 edges
    step(2);
    en_a = 0;
    step(10);
    chk("pause_gray", g_a, 0);
    chk("pause_valid", v_a, 0);
    en_a = 1;
    step(1);
    chk("resume_no_step", v_a, 0);
    step(1);
    chk("resume_gray", g_a, 3'b001);
    chk("resume_valid", v_a, 1);

    // Load coinciding with a tick: load wins
    step(3);
    ld_a = 1; lb_a = 3'd5;
    step(1);
    ld_a = 0;
    chk("load_gray", g_a, 3'b111);
    chk("load_valid", v_a, 1);
    step(3);
    chk("load_hold", g_a, 3'b111);
    step(1);
    chk("after_load_gray", g_a, 3'b101);   // bin 6

    // Reset mid-count while showing 110
    ld_a = 1; lb_a = 3'd4;
    step(1);
    ld_a = 0;
    chk("pre_rst_gray", g_a, 3'b110);
    step(2);
    rst = 1;
    step(1);
    rst = 0;
    chk("midrst_gray", g_a, 0);
    chk("midrst_valid", v_a, 0);
    step(3);
    chk("restart_hold", g_a, 0);
    step(1);
    chk("restart_gray", g_a, 3'b001);
    en_a = 0;

    // DIV=1: a step every clock, reset mid-run, then down-wrap
    en_c = 1;
    step(1); chk("c_g1", g_c, 3'b001); chk("c_v1", v_c, 1);
    step(1); chk("c_g2", g_c, 3'b011); chk("c_v2", v_c, 1);
    step(1); chk("c_g3", g_c, 3'b010);
    rst = 1;
    step(1);
    rst = 0;
    chk("c_rst_gray", g_c, 0);
    chk("c_rst_valid", v_c, 0);
    step(1); chk("c_restart", g_c, 3'b001);
    up_c = 0;
    step(1); chk("c_down0", g_c, 3'b000); chk("c_tc0", tc_c, 1);
    step(1); chk("c_wrap_down", g_c, 3'b100); chk("c_wrap_valid", v_c, 1);
    en_c = 0;

    // Saturating instance: down from 0 sticks, leaves when up flips
    en_b = 1; up_b = 0;
    step(3);
    chk("b_tc", tc_b, 1);
    step(1);
    chk("b_sat_gray", g_b, 0);
    chk("b_sat_valid", v_b, 0);
    step(5);
    chk("b_sat_hold", g_b, 0);
    up_b = 1;
    #1;
    chk("b_tc_flip", tc_b, 0);
    // SAT exit edge parks cnt at 0, so the step lands on the fifth edge
    step(4);
    chk("b_exit_hold", g_b, 0);
    step(1);
    chk("b_exit_gray", g_b, 3'b001);
    chk("b_exit_valid", v_b, 1);
    ld_b = 1; lb_b = 3'd7;
    step(1);
    ld_b = 0;
    chk("b_ld_max", g_b, 3'b100);
    chk("b_tc_max", tc_b, 1);
    step(3);
    step(1);
    chk("b_sat_max", g_b, 3'b100);
    chk("b_sat_max_valid", v_b, 0);
    en_b = 0; ld_b = 1; lb_b = 3'd2;
    step(1);
    ld_b = 0;
    chk("b_ld_idle", g_b, 3'b011);
    chk("b_ld_idle_valid", v_b, 1);
    step(6);
    chk("b_idle_hold", g_b, 3'b011);
    chk("b_idle_valid", v_b, 0);

    // Random en/up/load against reference model
    rst = 1;
    step(1);
    rst = 0;
    m_bin = 0; m_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      en_a = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) up_a = ~up_a;
      ld_a = ($urandom_range(0, 29) == 0);
      lb_a = 3'($urandom_range(0, 7));
      m_vld = 0;
      if (ld_a) begin
        m_bin = lb_a; m_cnt = 0; m_vld = 1;
      end else if (en_a) begin
        if (m_cnt == 3) begin
          m_cnt = 0; m_vld = 1;
          m_bin = up_a ? m_bin + 3'd1 : m_bin - 3'd1;
        end else begin
          m_cnt++;
        end
      end
      prev_g = g_a;
      step(1);
      chk("rnd_gray", g_a, gray3(m_bin));
      chk("rnd_valid", v_a, m_vld);
      if (m_vld && !ld_a) chk("rnd_onebit", $countones(prev_g ^ g_a), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
